// File: rtl/bip_pkg.sv
// Shared encodings for the BIP run sequencer: FSM states, halt opcode,
// report status codes and frame layout.
package bip_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RUN     = 3'd1;
  localparam logic [2:0] S_LATCH   = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = S_IDLE,
    RUN     = S_RUN,
    LATCH   = S_LATCH,
    SEND    = S_SEND,
    WAIT_TX = S_WAIT_TX
  } run_state_e;

  localparam logic [4:0] OP_HLT       = 5'b00000;
  localparam logic [7:0] STAT_HALT    = 8'h00;
  localparam logic [7:0] STAT_TIMEOUT = 8'h01;
  localparam int         FRAME_LEN    = 7;
  localparam int         FRAME_W      = 8 * FRAME_LEN;

  // Report frame, first byte to send in the most significant position.
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [7:0]  status,
                                                    input logic [15:0] cyc,
                                                    input logic [15:0] acc_v,
                                                    input logic [15:0] pc);
    return {status, cyc, acc_v, pc};
  endfunction

endpackage

// File: rtl/bip_run_controller_report_serializer.sv
// Streams a latched report frame byte by byte over a tx_start/tx_done
// handshake; owns the byte index and the byte mux.
module report_serializer
  import bip_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               last_byte
);

  localparam int IDX_W = $clog2(FRAME_LEN);

  logic [IDX_W-1:0] idx_reg;
  logic             tx_start_reg;
  logic             active_reg;
  logic [7:0]       frame_bytes [FRAME_LEN];

  genvar gi;
  generate
    for (gi = 0; gi < FRAME_LEN; gi++) begin : g_bytes
      assign frame_bytes[gi] = frame[FRAME_W-1-8*gi -: 8];
    end
  endgenerate

  // frame is held by the parent for the whole transfer, so the mux output is stable.
  assign tx_data   = frame_bytes[idx_reg];
  assign tx_start  = tx_start_reg;
  assign last_byte = (idx_reg == IDX_W'(FRAME_LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg      <= '0;
      tx_start_reg <= 1'b0;
      active_reg   <= 1'b0;
    end else begin
      tx_start_reg <= 1'b0;
      if (start) begin
        idx_reg      <= '0;
        tx_start_reg <= 1'b1;
        active_reg   <= 1'b1;
      end else if (active_reg && !tx_start_reg && tx_done) begin
        // tx_done coinciding with our own tx_start belongs to nothing we sent.
        if (last_byte) begin
          active_reg <= 1'b0;
        end else begin
          idx_reg      <= idx_reg + 1'b1;
          tx_start_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bip_run_controller.sv
// Run sequencer: starts the BIP core on a UART command, counts cycles until
// HALT or watchdog, then reports status/cycles/acc/pc over the UART.
module bip_run_controller
  import bip_pkg::*;
#(
  parameter int         AB        = 11,
  parameter int         DW        = 16,
  parameter int         CW        = 16,
  parameter logic [7:0] START_CMD = 8'h53
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx_done,
  input  logic [7:0]    rx_data,
  input  logic [4:0]    OpCode,
  input  logic [AB-1:0] Addr,
  input  logic [DW-1:0] acc,
  output logic          start_bip,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  input  logic          tx_done,
  output logic          busy
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  run_state_e         state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CW-1:0]      cnt_next;
  logic [7:0]         status_reg;
  logic [FRAME_W-1:0] snap_reg;
  logic               start_bip_reg;
  logic               busy_reg;
  logic               ser_last;
  logic               start_hit;

  assign start_hit = rx_done && (rx_data == START_CMD);
  assign cnt_next  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + {{(CW-1){1'b0}}, 1'b1};
  assign start_bip = start_bip_reg;
  assign busy      = busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      status_reg    <= STAT_HALT;
      snap_reg      <= '0;
      start_bip_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_hit) begin
            state_reg     <= RUN;
            cnt_reg       <= '0;
            start_bip_reg <= 1'b1;
            busy_reg      <= 1'b1;
          end
        end
        RUN: begin
          cnt_reg <= cnt_next;
          // Halt is checked first so it wins over a simultaneous watchdog hit.
          if (OpCode == OP_HLT) begin
            status_reg    <= STAT_HALT;
            state_reg     <= LATCH;
            start_bip_reg <= 1'b0;
          end else if (cnt_next == CNT_MAX) begin
            status_reg    <= STAT_TIMEOUT;
            state_reg     <= LATCH;
            start_bip_reg <= 1'b0;
          end
        end
        LATCH: begin
          snap_reg  <= pack_frame(status_reg, 16'(cnt_reg), acc, 16'(Addr));
          state_reg <= SEND;
        end
        SEND: begin
          state_reg <= WAIT_TX;
        end
        WAIT_TX: begin
          if (tx_done) begin
            if (ser_last) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= SEND;
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          start_bip_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  report_serializer u_serializer (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (state_reg == LATCH),
    .frame     (snap_reg),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .last_byte (ser_last)
  );

endmodule

// File: tb/tb_bip_run_controller.sv
// Scenario bench for bip_run_controller: expected report bytes are queued at
// stimulus time and compared against bytes captured from the tx handshake.
module tb_bip_run_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_done, rx_done4;
  logic [7:0]  rx_data;
  logic [4:0]  OpCode;
  logic [10:0] Addr;
  logic [15:0] acc;
  logic        tx_done, tx_done4, tx_done_drv, sel;
  logic        start_bip, tx_start, busy;
  logic        start_bip4, tx_start4, busy4;
  logic [7:0]  tx_data, tx_data4;
  logic        ts_s, bz_s;
  logic [7:0]  td_s;

  int checks = 0;
  int errors = 0;
  int pulse_err, stab_err;
  logic busy_before_last, busy_after;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] e, g;

  always #5 clk = ~clk;

  assign tx_done  = tx_done_drv & ~sel;
  assign tx_done4 = tx_done_drv & sel;
  assign ts_s = sel ? tx_start4 : tx_start;
  assign td_s = sel ? tx_data4  : tx_data;
  assign bz_s = sel ? busy4     : busy;

  bip_run_controller #(.AB(11), .DW(16), .CW(16), .START_CMD(8'h53)) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .OpCode(OpCode), .Addr(Addr), .acc(acc), .start_bip(start_bip),
    .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done), .busy(busy)
  );

  bip_run_controller #(.AB(11), .DW(16), .CW(4), .START_CMD(8'h53)) dut4 (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done4), .rx_data(rx_data),
    .OpCode(OpCode), .Addr(Addr), .acc(acc), .start_bip(start_bip4),
    .tx_start(tx_start4), .tx_data(tx_data4), .tx_done(tx_done4), .busy(busy4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic push_expected(input logic [7:0] st, input logic [15:0] cyc,
                               input logic [15:0] acc_v, input logic [15:0] pc);
    exp_q.push_back(st);
    exp_q.push_back(cyc[15:8]);
    exp_q.push_back(cyc[7:0]);
    exp_q.push_back(acc_v[15:8]);
    exp_q.push_back(acc_v[7:0]);
    exp_q.push_back(pc[15:8]);
    exp_q.push_back(pc[7:0]);
  endtask

  // Acts as the UART transmitter: captures each byte, acknowledges after 'delay' cycles.
  task automatic serve_frame(input int nbytes, input int delay,
                             input bit early_done, input bit poke_rx);
    logic [7:0] cur;
    int n;
    pulse_err = 0;
    stab_err  = 0;
    for (int b = 0; b < nbytes; b++) begin
      n = 0;
      while (!ts_s && n < 200) begin
        tick();
        n++;
      end
      if (!ts_s) begin
        checks++;
        errors++;
        $display("FAIL tx_start_wait byte %0d: tx_start=0 after 200 cycles, required 1", b);
        return;
      end
      cur = td_s;
      got_q.push_back(cur);
      if (early_done) tx_done_drv = 1'b1;
      tick();
      tx_done_drv = 1'b0;
      if (ts_s) pulse_err++;
      for (int d = 0; d < delay; d++) begin
        if (td_s !== cur) stab_err++;
        if (poke_rx && d == 0) begin
          rx_data = 8'h53;
          rx_done = 1'b1;
        end
        tick();
        rx_done = 1'b0;
      end
      if (td_s !== cur) stab_err++;
      if (b == 6) busy_before_last = bz_s;
      tx_done_drv = 1'b1;
      tick();
      tx_done_drv = 1'b0;
      if (b == 6) busy_after = bz_s;
    end
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    #12;
    checks++;
    if ({start_bip, tx_start, busy, tx_data} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %03h, required 000", {start_bip, tx_start, busy, tx_data});
    end
    rst_n = 1'b1;
    tick();
    send_rx(8'h41);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (start_bip || busy || tx_start) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL other_byte_ignored: got %0d active cycles, required 0", bad);
    end
    $display("test_reset: done");
  endtask

  task automatic test_halt();
    int hi = 0;
    acc = 16'h1234; Addr = 11'h00A; OpCode = 5'h01;
    push_expected(8'h00, 16'h000A, 16'h1234, 16'h000A);
    send_rx(8'h53);
    for (int i = 0; i < 9; i++) begin
      if (start_bip) hi++;
      tick();
    end
    OpCode = 5'h00;
    if (start_bip) hi++;
    tick();
    OpCode = 5'h01;
    checks++;
    if (start_bip !== 1'b0 || hi != 10) begin
      errors++;
      $display("FAIL halt_run_len: got %0d cycles (start_bip now %b), required 10 (0)", hi, start_bip);
    end
    checks++;
    if (tx_start !== 1'b0) begin
      errors++;
      $display("FAIL halt_latch_cycle: tx_start=%b, required 0", tx_start);
    end
    tick();
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL halt_latency: tx_start=%b two cycles after HALT, required 1", tx_start);
    end
    serve_frame(7, 0, 1'b0, 1'b0);
    checks++;
    if (pulse_err !== 0) begin
      errors++;
      $display("FAIL halt_pulse_width: got %0d long pulses, required 0", pulse_err);
    end
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("FAIL halt_frame_len: got %0d bytes, required 7", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL halt_byte: got %02h, required %02h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    $display("test_halt: done");
  endtask

  task automatic test_timeout();
    int hi = 0;
    int n = 0;
    sel = 1'b1;
    acc = 16'hCAFE; Addr = 11'h123; OpCode = 5'h01;
    push_expected(8'h01, 16'h000F, 16'hCAFE, 16'h0123);
    rx_data = 8'h53; rx_done4 = 1'b1;
    tick();
    rx_done4 = 1'b0;
    while (start_bip4 && n < 40) begin
      hi++;
      tick();
      n++;
    end
    checks++;
    if (hi != 15) begin
      errors++;
      $display("FAIL timeout_run_len: got %0d cycles, required 15", hi);
    end
    serve_frame(7, 0, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("FAIL timeout_frame_len: got %0d bytes, required 7", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL timeout_byte: got %02h, required %02h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    sel = 1'b0;
    $display("test_timeout: done");
  endtask

  task automatic test_slow_tx();
    acc = 16'hBEEF; Addr = 11'h7FF; OpCode = 5'h01;
    push_expected(8'h00, 16'h0003, 16'hBEEF, 16'h07FF);
    send_rx(8'h53);
    tick();
    tick();
    OpCode = 5'h00;
    tick();
    OpCode = 5'h01;
    tick();
    acc = 16'h0000; Addr = 11'h000;
    serve_frame(7, 20, 1'b0, 1'b0);
    checks++;
    if (stab_err !== 0) begin
      errors++;
      $display("FAIL slow_tx_data_stable: got %0d changes, required 0", stab_err);
    end
    checks++;
    if (busy_before_last !== 1'b1 || busy_after !== 1'b0) begin
      errors++;
      $display("FAIL slow_busy_fall: got before=%b after=%b, required 1 0", busy_before_last, busy_after);
    end
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("FAIL slow_frame_len: got %0d bytes, required 7", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL slow_byte: got %02h, required %02h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    $display("test_slow_tx: done");
  endtask

  task automatic test_reset_abort();
    int n = 0;
    acc = 16'h5555; Addr = 11'h0AA; OpCode = 5'h01;
    send_rx(8'h53);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_bip !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_run: got start_bip=%b busy=%b, required 0 0", start_bip, busy);
    end
    #2 rst_n = 1'b1;
    tick();
    send_rx(8'h53);
    OpCode = 5'h00;
    tick();
    OpCode = 5'h01;
    tick();
    serve_frame(2, 3, 1'b0, 1'b0);
    while (!tx_start && n < 50) begin
      tick();
      n++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({start_bip, tx_start, busy, tx_data} !== 11'd0 || n >= 50) begin
      errors++;
      $display("FAIL abort_frame: got %03h (wait %0d), required 000", {start_bip, tx_start, busy, tx_data}, n);
    end
    #2 rst_n = 1'b1;
    exp_q.delete(); got_q.delete();
    tick();
    acc = 16'h0F0F; Addr = 11'h400;
    push_expected(8'h00, 16'h0005, 16'h0F0F, 16'h0400);
    send_rx(8'h53);
    for (int i = 0; i < 4; i++) tick();
    OpCode = 5'h00;
    tick();
    OpCode = 5'h01;
    serve_frame(7, 1, 1'b0, 1'b0);
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("FAIL rerun_frame_len: got %0d bytes, required 7", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rerun_byte: got %02h, required %02h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    $display("test_reset_abort: done");
  endtask

  task automatic test_back_to_back();
    int extra = 0;
    acc = 16'hA5A5; Addr = 11'h055; OpCode = 5'h01;
    push_expected(8'h00, 16'h0003, 16'hA5A5, 16'h0055);
    send_rx(8'h53);
    tick();
    send_rx(8'h53);
    OpCode = 5'h00;
    tick();
    OpCode = 5'h01;
    tick();
    serve_frame(7, 2, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (tx_start || start_bip) extra++;
      tick();
    end
    checks++;
    if (extra !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_single_frame: got %0d extra active cycles busy=%b, required 0 0", extra, busy);
    end
    checks++;
    if (got_q.size() != 7) begin
      errors++;
      $display("FAIL b2b_frame_len: got %0d bytes, required 7", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL b2b_byte: got %02h, required %02h", g, e);
      end
    end
    exp_q.delete(); got_q.delete();
    $display("test_back_to_back: done");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; rx_done = 1'b0; rx_done4 = 1'b0; rx_data = 8'h00;
    OpCode = 5'h01; Addr = '0; acc = '0; tx_done_drv = 1'b0; sel = 1'b0;
    busy_before_last = 1'b0; busy_after = 1'b1;
    test_reset();
    test_halt();
    test_timeout();
    test_slow_tx();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bip_run_controller.md
Name: bip_run_controller

Overview:
Top-level run sequencer for the BIP core. Waits for a start command byte from the UART receiver, enables the program counter, and counts execution cycles until the HALT opcode (5'b00000) is decoded or a watchdog limit is hit. It then freezes the core, snapshots results, and streams a 7-byte report frame to the UART transmitter using a start/done handshake. Sits between the UART rx/tx blocks and Control_Block, and drives Control_Block's start_bip input.

Parameters:
AB, 11, program address width (matches Control_Block).
DW, 16, accumulator width; the report frame carries exactly 2 bytes, so DW must be 16.
CW, 16, cycle counter width; the watchdog limit is 2^CW-1.
START_CMD, 8'h53, rx byte that launches a run.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx_done  in  1  one-cycle pulse: rx_data valid
rx_data  in  8  received UART byte
OpCode  in  5  opcode currently decoded by Control_Block
Addr  in  AB  current program counter
acc  in  DW  accumulator value
start_bip  out  1  run enable to Control_Block/PC
tx_start  out  1  one-cycle pulse: launch transmission of tx_data
tx_data  out  8  byte to transmit; stable from tx_start until tx_done
tx_done  in  1  one-cycle pulse: tx byte finished
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; start_bip=0, tx_start=0, tx_data=0, busy=0; cycle counter, snapshot registers, and byte index cleared. Reset mid-run or mid-frame aborts immediately. No partial-frame resume.
- IDLE: rx_done=1 with rx_data==START_CMD -> RUN, clear counter, start_bip=1 from the next cycle. Other bytes are ignored.
- RUN: start_bip=1; counter increments every cycle, saturating at 2^CW-1.
  - OpCode==0 -> LATCH, status=8'h00. The halt cycle is counted. start_bip drops in the same cycle as the state change, so the PC does not advance past HALT.
  - Counter reaches 2^CW-1 with no halt -> LATCH, status=8'h01 (timeout).
  - Halt and limit in the same cycle -> status 8'h00 (halt wins).
- LATCH (1 cycle): snapshot status, counter, acc, and Addr zero-extended to 16 bits. Set byte index=0, then -> SEND.
- Frame order: [status, cyc[15:8], cyc[7:0], acc[15:8], acc[7:0], pc[15:8], pc[7:0]]. Content comes only from snapshot registers; live inputs are ignored after LATCH.
- SEND: drive tx_data=frame[idx], pulse tx_start for exactly one cycle, -> WAIT_TX.
- WAIT_TX: hold tx_data. On tx_done: if idx==6 -> IDLE, otherwise idx+1 -> SEND. A tx_done arriving in the same cycle as tx_start is ignored.
- rx_done in any state other than IDLE is ignored, including START_CMD during RUN or SEND.
- Latency: START_CMD pulse -> start_bip=1 after 1 cycle. HALT decoded -> first tx_start after 2 cycles (LATCH, then SEND).
- The FSM has 5 states, binary encoded. Unreachable state codes -> IDLE.

Decomposition:
- Shared package `bip_pkg`:
  - state encoding localparams (IDLE, RUN, LATCH, SEND, WAIT_TX)
  - OP_HLT=5'b00000
  - STAT_HALT=8'h00, STAT_TIMEOUT=8'h01
  - FRAME_LEN=7
- One natural sub-module: `report_serializer`. It takes the 56-bit snapshot, a start strobe, and the tx_start/tx_done handshake, and owns byte index, byte mux, and handshake. The parent keeps the run FSM and counter.

Test Plan:
- Reset, then rx byte 8'h41 -> start_bip stays 0, busy=0, no tx_start.
- rx 8'h53; OpCode nonzero for 9 cycles, then 0; acc=16'h1234, Addr=11'h00A -> start_bip high for 10 cycles. Frame 00,00,0A,12,34,00,0A sent; each tx_start is a single-cycle pulse, and the next byte waits for tx_done.
- CW=4 build, OpCode never 0 -> stop after 15 counted cycles; status byte 01, cycle bytes 00,0F.
- tx_done delayed 20 cycles per byte, acc changed after LATCH -> tx_data held stable, frame carries the snapshot acc, busy falls only after the 7th tx_done.
- rst_n asserted during RUN and again during byte 3 of a frame -> all outputs 0 immediately; a new 8'h53 runs cleanly from counter 0.
- rx 8'h53 during RUN and during WAIT_TX -> ignored; exactly one 7-byte frame is produced.
